// File: rtl/store_trace_checker_pkg.sv
// store_trace_checker_pkg
//   Shared types and elaboration helpers for the store-trace checker.
//   chk_state_t : checker FSM state, also driven out on state_o.
//   cfg_kind_t  : meaning of a configuration write.
package store_trace_checker_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } chk_state_t;

    typedef enum logic [1:0] {
        CFG_EXP = 2'd0,
        CFG_IGN = 2'd1,
        CFG_LEN = 2'd2,
        CFG_RSV = 2'd3
    } cfg_kind_t;

    // $clog2 that never returns 0, so depth-1 tables still get a 1-bit index.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/store_trace_checker_if.sv
// store_trace_checker_if
//   Groups the observed data-memory write port with the runtime configuration
//   port of the checker.
//   MemWrite/DataAdr/WriteData : store strobe, address and data from the core
//   cfg_we/cfg_kind/cfg_idx/cfg_addr/cfg_data : table / length configuration
//   start                      : one-cycle arm pulse
//   master : the side producing stores and configuration (core / bench)
//   slave  : the checker
interface store_trace_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
);
    import store_trace_checker_pkg::*;

    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              cfg_we;
    cfg_kind_t         cfg_kind;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              start;

    modport master (
        output MemWrite, DataAdr, WriteData,
        output cfg_we, cfg_kind, cfg_idx, cfg_addr, cfg_data,
        output start
    );

    modport slave (
        input MemWrite, DataAdr, WriteData,
        input cfg_we, cfg_kind, cfg_idx, cfg_addr, cfg_data,
        input start
    );

endinterface

// File: rtl/store_trace_checker_ign_match.sv
// store_ign_match
//   NUM_IGN-way parallel compare of a store address against the ignore table.
//   addr     : store address under test
//   ign_addr : ignore-table addresses
//   ign_vld  : per-entry valid bits; invalid entries never hit
//   hit      : address matches at least one valid entry
module store_ign_match #(
    parameter int ADDR_W  = 32,
    parameter int NUM_IGN = 4
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [NUM_IGN-1:0][ADDR_W-1:0] ign_addr,
    input  logic [NUM_IGN-1:0]             ign_vld,
    output logic                           hit
);

    logic [NUM_IGN-1:0] eq;

    always_comb begin
        eq = '0;
        for (int i = 0; i < NUM_IGN; i++) begin
            eq[i] = ign_vld[i] && (ign_addr[i] == addr);
        end
    end

    assign hit = |eq;

endmodule

// File: rtl/store_trace_checker.sv
// store_trace_checker
//   Watches the data-memory write port and compares each store against a
//   runtime-loaded table of expected {address,data} pairs, skipping stores to
//   addresses in an ignore table. Ends in PASS, FAIL or TIMEOUT and captures
//   the offending store on FAIL.
//   clk, reset       : clock, asynchronous active-low reset
//   bus (slave)      : store port, configuration port and start pulse
//   state_o          : current FSM state
//   done             : state is PASS, FAIL or TIMEOUT
//   pass/fail/timeout: mutually exclusive verdict flags
//   match_cnt        : expected entries matched since arming
//   ign_cnt          : ignored stores since arming (saturating)
//   fail_addr/data   : the store that caused FAIL
//   fail_idx         : expected index at failure (ordered mode), else 0
module store_trace_checker
    import store_trace_checker_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int NUM_EXP      = 8,
    parameter int NUM_IGN      = 4,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int STRICT_ORDER = 1,
    localparam int IDX_W  = clog2_min1(imax(NUM_EXP, NUM_IGN)),
    localparam int CNT_W  = clog2_min1(NUM_EXP + 1),
    localparam int FIDX_W = clog2_min1(NUM_EXP)
) (
    input  logic                  clk,
    input  logic                  reset,
    store_trace_checker_if.slave  bus,
    output chk_state_t            state_o,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [15:0]           ign_cnt,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [DATA_W-1:0]     fail_data,
    output logic [FIDX_W-1:0]     fail_idx
);

    localparam int CYC_W = clog2_min1(TIMEOUT_CYC + 1);

    chk_state_t state, state_n;

    logic [NUM_EXP-1:0][ADDR_W-1:0] exp_addr;
    logic [NUM_EXP-1:0][DATA_W-1:0] exp_data;
    logic [NUM_EXP-1:0]             exp_vld;
    logic [NUM_EXP-1:0]             hit;
    logic [NUM_IGN-1:0][ADDR_W-1:0] ign_addr;
    logic [NUM_IGN-1:0]             ign_vld;
    logic [CNT_W-1:0]               exp_len;
    logic [CYC_W-1:0]               cyc_cnt;

    logic               ign_hit;
    logic               sel_vld;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               strict_ok;
    logic               uo_found;
    logic [NUM_EXP-1:0] uo_vec;
    logic               match_ok;
    logic [CNT_W-1:0]   cnt_inc;
    logic               store_ev;
    logic               eval;
    logic               tmo;
    logic               arm;

    store_ign_match #(
        .ADDR_W  (ADDR_W),
        .NUM_IGN (NUM_IGN)
    ) u_ign (
        .addr     (bus.DataAdr),
        .ign_addr (ign_addr),
        .ign_vld  (ign_vld),
        .hit      (ign_hit)
    );

    // Ordered mode looks only at exp[match_cnt]; unordered mode searches for
    // the lowest-index entry inside exp_len that has not been consumed yet.
    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        uo_found = 1'b0;
        uo_vec   = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (match_cnt == CNT_W'(i)) begin
                sel_vld  = exp_vld[i];
                sel_addr = exp_addr[i];
                sel_data = exp_data[i];
            end
            if (!uo_found && exp_vld[i] && !hit[i] && (CNT_W'(i) < exp_len) &&
                (exp_addr[i] == bus.DataAdr) && (exp_data[i] == bus.WriteData)) begin
                uo_found  = 1'b1;
                uo_vec[i] = 1'b1;
            end
        end
    end

    assign strict_ok = sel_vld && (sel_addr == bus.DataAdr) && (sel_data == bus.WriteData);
    assign match_ok  = (STRICT_ORDER != 0) ? strict_ok : uo_found;
    assign cnt_inc   = match_cnt + 1'b1;
    assign store_ev  = (state == ARMED) && bus.MemWrite;
    // Ignored stores never reach the expect logic; an empty table passes outright.
    assign eval      = store_ev && !ign_hit && (exp_len != '0);
    assign tmo       = (TIMEOUT_CYC != 0) &&
                       (({1'b0, cyc_cnt} + 1'b1) == (CYC_W + 1)'(TIMEOUT_CYC));
    assign arm       = (state != ARMED) && bus.start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Store verdicts are tested before the timeout so a store landing on the
    // timeout edge decides the outcome.
    always_comb begin
        state_n = state;
        case (state)
            ARMED: begin
                if (exp_len == '0) begin
                    state_n = PASS;
                end else if (eval && match_ok && (cnt_inc == exp_len)) begin
                    state_n = PASS;
                end else if (eval && !match_ok) begin
                    state_n = FAIL;
                end else if (tmo) begin
                    state_n = TIMEOUT;
                end
            end
            default: begin
                if (bus.start) begin
                    state_n = ARMED;
                end
            end
        endcase
    end

    assign state_o = state;
    assign pass    = (state == PASS);
    assign fail    = (state == FAIL);
    assign timeout = (state == TIMEOUT);
    assign done    = pass || fail || timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_addr  <= '0;
            exp_data  <= '0;
            exp_vld   <= '0;
            hit       <= '0;
            ign_addr  <= '0;
            ign_vld   <= '0;
            exp_len   <= '0;
            cyc_cnt   <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_idx  <= '0;
        end else begin
            // Tables are frozen while a check is running.
            if (bus.cfg_we && (state != ARMED)) begin
                case (bus.cfg_kind)
                    CFG_EXP: begin
                        for (int i = 0; i < NUM_EXP; i++) begin
                            if (bus.cfg_idx == IDX_W'(i)) begin
                                exp_addr[i] <= bus.cfg_addr;
                                exp_data[i] <= bus.cfg_data;
                                exp_vld[i]  <= 1'b1;
                            end
                        end
                    end
                    CFG_IGN: begin
                        for (int i = 0; i < NUM_IGN; i++) begin
                            if (bus.cfg_idx == IDX_W'(i)) begin
                                ign_addr[i] <= bus.cfg_addr;
                                ign_vld[i]  <= 1'b1;
                            end
                        end
                    end
                    CFG_LEN: begin
                        if (bus.cfg_data > DATA_W'(NUM_EXP)) begin
                            exp_len <= CNT_W'(NUM_EXP);
                        end else begin
                            exp_len <= bus.cfg_data[CNT_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end

            // A store on the arming edge is deliberately not evaluated.
            if (arm) begin
                cyc_cnt   <= '0;
                match_cnt <= '0;
                ign_cnt   <= '0;
                hit       <= '0;
                fail_addr <= '0;
                fail_data <= '0;
                fail_idx  <= '0;
            end else if (state == ARMED) begin
                cyc_cnt <= cyc_cnt + 1'b1;
                if (store_ev && ign_hit) begin
                    if (ign_cnt != 16'hFFFF) begin
                        ign_cnt <= ign_cnt + 1'b1;
                    end
                end else if (eval) begin
                    if (match_ok) begin
                        match_cnt <= cnt_inc;
                        hit       <= hit | uo_vec;
                    end else begin
                        fail_addr <= bus.DataAdr;
                        fail_data <= bus.WriteData;
                        fail_idx  <= (STRICT_ORDER != 0) ? FIDX_W'(match_cnt) : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// tb_store_trace_checker
//   Drives an ordered and an unordered checker from the same bus and compares
//   both against hand-computed expectations (vector table plus hand-written
//   multi-cycle sequences).
module tb_store_trace_checker;
    import store_trace_checker_pkg::*;

    logic clk;
    logic rst_n;

    chk_state_t  s_state, u_state;
    logic        s_done, s_pass, s_fail, s_tmo;
    logic        u_done, u_pass, u_fail, u_tmo;
    logic [3:0]  s_match, u_match;
    logic [15:0] s_ign, u_ign;
    logic [31:0] s_faddr, s_fdata, u_faddr, u_fdata;
    logic [2:0]  s_fidx, u_fidx;

    int nvec = 0;
    int nerr = 0;

    store_trace_checker_if #(.ADDR_W(32), .DATA_W(32), .IDX_W(3)) bus ();

    store_trace_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(8), .NUM_IGN(4),
        .TIMEOUT_CYC(20), .STRICT_ORDER(1)
    ) dut_s (
        .clk(clk), .reset(rst_n), .bus(bus),
        .state_o(s_state), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_tmo),
        .match_cnt(s_match), .ign_cnt(s_ign),
        .fail_addr(s_faddr), .fail_data(s_fdata), .fail_idx(s_fidx)
    );

    store_trace_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(8), .NUM_IGN(4),
        .TIMEOUT_CYC(20), .STRICT_ORDER(0)
    ) dut_u (
        .clk(clk), .reset(rst_n), .bus(bus),
        .state_o(u_state), .done(u_done), .pass(u_pass), .fail(u_fail), .timeout(u_tmo),
        .match_cnt(u_match), .ign_cnt(u_ign),
        .fail_addr(u_faddr), .fail_data(u_fdata), .fail_idx(u_fidx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        cfg_we;
        cfg_kind_t   kind;
        logic [2:0]  idx;
        logic [31:0] caddr;
        logic [31:0] cdata;
        logic        start;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        chk;
        chk_state_t  st_s;
        chk_state_t  st_u;
        int          m_s;
        int          m_u;
        int          ign;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t rc(input cfg_kind_t k, input logic [2:0] ix,
                                input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        v.cfg_we = 1'b1; v.kind = k; v.idx = ix; v.caddr = a; v.cdata = d;
        v.start = 1'b0; v.mw = 1'b0; v.adr = '0; v.wd = '0;
        v.chk = 1'b0; v.st_s = IDLE; v.st_u = IDLE; v.m_s = 0; v.m_u = 0; v.ign = 0;
        return v;
    endfunction

    function automatic vec_t rs(input logic st, input logic mw,
                                input logic [31:0] a, input logic [31:0] d,
                                input chk_state_t es, input chk_state_t eu,
                                input int ms, input int mu, input int ig);
        vec_t v;
        v.cfg_we = 1'b0; v.kind = CFG_EXP; v.idx = '0; v.caddr = '0; v.cdata = '0;
        v.start = st; v.mw = mw; v.adr = a; v.wd = d;
        v.chk = 1'b1; v.st_s = es; v.st_u = eu; v.m_s = ms; v.m_u = mu; v.ign = ig;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic st, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic cw, input cfg_kind_t k,
                         input logic [2:0] ix, input logic [31:0] ca, input logic [31:0] cd);
        bus.start     = st;
        bus.MemWrite  = mw;
        bus.DataAdr   = a;
        bus.WriteData = d;
        bus.cfg_we    = cw;
        bus.cfg_kind  = k;
        bus.cfg_idx   = ix;
        bus.cfg_addr  = ca;
        bus.cfg_data  = cd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, CFG_EXP, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input chk_state_t es, input chk_state_t eu,
                            input int ms, input int mu);
        chk({tag, " state_s"}, 32'(s_state), 32'(es));
        chk({tag, " state_u"}, 32'(u_state), 32'(eu));
        chk({tag, " match_s"}, 32'(s_match), 32'(ms));
        chk({tag, " match_u"}, 32'(u_match), 32'(mu));
        chk({tag, " pass_s"}, 32'(s_pass), 32'(es == PASS));
        chk({tag, " tmo_s"}, 32'(s_tmo), 32'(es == TIMEOUT));
        chk({tag, " done_u"}, 32'(u_done), 32'((eu == PASS) || (eu == FAIL) || (eu == TIMEOUT)));
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vq[i].start, vq[i].mw, vq[i].adr, vq[i].wd, vq[i].cfg_we,
                  vq[i].kind, vq[i].idx, vq[i].caddr, vq[i].cdata);
            tick();
            if (vq[i].chk) begin
                chk_both($sformatf("row%0d", i), vq[i].st_s, vq[i].st_u, vq[i].m_s, vq[i].m_u);
                chk($sformatf("row%0d fail_s", i), 32'(s_fail), 32'(vq[i].st_s == FAIL));
                chk($sformatf("row%0d ign_s", i), 32'(s_ign), 32'(vq[i].ign));
                chk($sformatf("row%0d ign_u", i), 32'(u_ign), 32'(vq[i].ign));
            end
        end
    endtask

    initial begin
        int n1;

        // Legacy single-store check: ignored store then the expected one.
        vq.push_back(rc(CFG_EXP, 3'd0, 32'd100, 32'd7));
        vq.push_back(rc(CFG_IGN, 3'd0, 32'd96, 32'd0));
        vq.push_back(rc(CFG_LEN, 3'd0, 32'd0, 32'd1));
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'd96,    32'h55,   ARMED, ARMED, 0, 0, 1));
        vq.push_back(rs(1'b0, 1'b1, 32'd100,   32'd7,    PASS,  PASS,  1, 1, 1));
        vq.push_back(rs(1'b0, 1'b1, 32'h200,   32'd9,    PASS,  PASS,  1, 1, 1));
        // Data mismatch on the second of two expected stores.
        vq.push_back(rc(CFG_EXP, 3'd0, 32'h10, 32'd1));
        vq.push_back(rc(CFG_EXP, 3'd1, 32'h14, 32'd2));
        vq.push_back(rc(CFG_LEN, 3'd0, 32'd0, 32'd2));
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h10,    32'd1,    ARMED, ARMED, 1, 1, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h14,    32'd3,    FAIL,  FAIL,  1, 1, 0));
        n1 = vq.size();
        // Reversed order: fails ordered, passes unordered.
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h14,    32'd2,    FAIL,  ARMED, 0, 1, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h10,    32'd1,    FAIL,  PASS,  0, 2, 0));
        // A, B, C presented as C, A, B; then a repeated A.
        vq.push_back(rc(CFG_EXP, 3'd0, 32'h20, 32'hA));
        vq.push_back(rc(CFG_EXP, 3'd1, 32'h24, 32'hB));
        vq.push_back(rc(CFG_EXP, 3'd2, 32'h28, 32'hC));
        vq.push_back(rc(CFG_LEN, 3'd0, 32'd0, 32'd3));
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h28,    32'hC,    FAIL,  ARMED, 0, 1, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h20,    32'hA,    FAIL,  ARMED, 0, 2, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h24,    32'hB,    FAIL,  PASS,  0, 3, 0));
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h20,    32'hA,    ARMED, ARMED, 1, 1, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h20,    32'hA,    FAIL,  FAIL,  1, 1, 0));
        // Ignore index beyond the table depth is dropped: store is not ignored.
        vq.push_back(rc(CFG_IGN, 3'd5, 32'h40, 32'd0));
        vq.push_back(rc(CFG_LEN, 3'd0, 32'd0, 32'd1));
        vq.push_back(rs(1'b1, 1'b0, 32'd0,     32'd0,    ARMED, ARMED, 0, 0, 0));
        vq.push_back(rs(1'b0, 1'b1, 32'h40,    32'd0,    FAIL,  FAIL,  0, 0, 0));

        // Reset state.
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk_both("reset", IDLE, IDLE, 0, 0);
        chk("reset ign_s", 32'(s_ign), 32'd0);
        chk("reset fail_addr_s", s_faddr, 32'd0);
        chk("reset fail_data_u", u_fdata, 32'd0);
        chk("reset fail_idx_s", 32'(s_fidx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        apply_rows(0, n1);
        chk("mismatch fail_addr_s", s_faddr, 32'h14);
        chk("mismatch fail_data_s", s_fdata, 32'd3);
        chk("mismatch fail_idx_s", 32'(s_fidx), 32'd1);
        chk("mismatch fail_addr_u", u_faddr, 32'h14);
        chk("mismatch fail_idx_u", 32'(u_fidx), 32'd0);
        apply_rows(n1, vq.size());

        // Timeout after 20 ARMED cycles with no stores (exp = {A}, len 1).
        drive(1'b1, 1'b0, '0, '0, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        idle();
        repeat (19) tick();
        chk_both("tmo19", ARMED, ARMED, 0, 0);
        tick();
        chk_both("tmo20", TIMEOUT, TIMEOUT, 0, 0);
        chk("tmo20 timeout_u", 32'(u_tmo), 32'd1);

        // Matching store on the timeout edge: the store verdict wins.
        drive(1'b1, 1'b0, '0, '0, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        idle();
        repeat (19) tick();
        drive(1'b0, 1'b1, 32'h20, 32'hA, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        chk_both("race", PASS, PASS, 1, 1);
        chk("race timeout_s", 32'(s_tmo), 32'd0);

        // Store coincident with start is not evaluated.
        drive(1'b1, 1'b1, 32'h20, 32'hA, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        chk_both("armcyc", ARMED, ARMED, 0, 0);
        idle();
        tick();
        chk_both("armcyc+1", ARMED, ARMED, 0, 0);
        // Table write while ARMED must be ignored; A still passes.
        drive(1'b0, 1'b0, '0, '0, 1'b1, CFG_EXP, 3'd0, 32'h30, 32'd3);
        tick();
        drive(1'b0, 1'b1, 32'h20, 32'hA, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        chk_both("armedcfg", PASS, PASS, 1, 1);

        // Asynchronous reset in the middle of a run.
        drive(1'b1, 1'b0, '0, '0, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        idle();
        chk_both("prerst", ARMED, ARMED, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_both("asyncrst", IDLE, IDLE, 0, 0);
        chk("asyncrst fail_s", 32'(s_fail), 32'd0);
        chk("asyncrst done_s", 32'(s_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b1, 1'b0, '0, '0, 1'b0, CFG_EXP, '0, '0, '0);
        tick();
        chk_both("rearm", ARMED, ARMED, 0, 0);
        idle();
        tick();
        chk_both("emptylen", PASS, PASS, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
